// File: rtl/updown_sweep_ctrl.sv
//------------------------------------------------------------------------------
// updown_sweep_ctrl : drives an external up/down counter through triangle sweeps
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module updown_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [REP_W-1:0] reps,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] rep_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_RISE = 2'd2,
    S_FALL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_idx_q, rep_idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [REP_W-1:0] rep_inc;
  logic             out_of_range;

  assign rep_inc      = rep_idx_q + {{(REP_W-1){1'b0}}, 1'b1};
  assign out_of_range = (count_in < lo_q) || (count_in > hi_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      reps_q    <= '0;
      rep_idx_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      reps_q    <= reps_d;
      rep_idx_q <= rep_idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    reps_d    = reps_q;
    rep_idx_d = rep_idx_q;
    done_d    = 1'b0;
    err_d     = err_q;
    cnt_en    = 1'b0;
    cnt_dir   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            lo_d      = lo;
            hi_d      = hi;
            reps_d    = reps;
            rep_idx_d = '0;
            err_d     = 1'b0;
            state_d   = S_SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SEEK: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (count_in < lo_q) begin
          cnt_en  = 1'b1;
          cnt_dir = 1'b1;
        end else if (count_in > lo_q) begin
          cnt_en = 1'b1;
        end else begin
          state_d = S_RISE;
        end
      end

      S_RISE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (out_of_range) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (count_in < hi_q) begin
          cnt_en  = 1'b1;
          cnt_dir = 1'b1;
        end else begin
          state_d = S_FALL;
        end
      end

      S_FALL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (out_of_range) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (count_in > lo_q) begin
          cnt_en = 1'b1;
        end else begin
          // Low turning point closes one triangle; reps of zero never finishes.
          rep_idx_d = rep_inc;
          if ((reps_q != '0) && (rep_inc == reps_q)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RISE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign rep_idx = rep_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a behavioural counter beside the DUT and a
// queue of expected values pushed before each stimulus step.
`default_nettype none

module tb_updown_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] lo_s;
  logic [3:0] hi_s;
  logic [7:0] reps_s;
  logic [3:0] cnt;
  logic       cnt_en;
  logic       cnt_dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rep_idx;

  logic       ld;
  logic [3:0] ld_val;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  updown_sweep_ctrl #(.WIDTH(4), .REP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .lo       (lo_s),
    .hi       (hi_s),
    .reps     (reps_s),
    .count_in (cnt),
    .cnt_en   (cnt_en),
    .cnt_dir  (cnt_dir),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rep_idx  (rep_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controlled counter; a load models an external disturbance.
  always @(posedge clk) begin
    if (ld)          cnt <= ld_val;
    else if (cnt_en) cnt <= cnt_dir ? cnt + 4'd1 : cnt - 4'd1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic load(input int v);
    ld     = 1'b1;
    ld_val = 4'(v);
    @(negedge clk);
    ld     = 1'b0;
  endtask

  task automatic do_start(input int l, input int h, input int r);
    lo_s   = 4'(l);
    hi_s   = 4'(h);
    reps_s = 8'(r);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run_busy(input int budget, output int nb, output int nu, output int nd);
    nb = 0; nu = 0; nd = 0;
    while (busy === 1'b1 && nb < budget) begin
      nb++;
      if (cnt_en && cnt_dir)  nu++;
      if (cnt_en && !cnt_dir) nd++;
      @(negedge clk);
    end
  endtask

  // Full run from counter value c; expectations come from the latency formulas.
  task automatic sweep_case(input string tag, input int c, input int l, input int h, input int r);
    int seek, nb, nu, nd;
    seek = ((c > l) ? c - l : l - c) + 1;
    push(0);
    push(1);
    push(seek + r * (2 * (h - l) + 2));
    push(((c < l) ? l - c : 0) + r * (h - l));
    push(((c > l) ? c - l : 0) + r * (h - l));
    push(1);
    push(r);
    push(l);
    push(0);
    load(c);
    do_start(l, h, r);
    chk({tag, "_err_clr"}, err);
    chk({tag, "_busy1"}, busy);
    run_busy(2000, nb, nu, nd);
    chk({tag, "_busy_cycles"}, nb);
    chk({tag, "_up_cycles"}, nu);
    chk({tag, "_down_cycles"}, nd);
    chk({tag, "_done"}, done);
    chk({tag, "_rep_idx"}, rep_idx);
    chk({tag, "_count_end"}, cnt);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done);
  endtask

  initial begin
    int en_seen;
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    lo_s = '0; hi_s = '0; reps_s = '0; ld = 1'b0; ld_val = '0;
    repeat (3) @(negedge clk);
    push(0); push(0); push(0); push(0); push(0); push(0);
    chk("rst_busy", busy);
    chk("rst_en", cnt_en);
    chk("rst_dir", cnt_dir);
    chk("rst_done", done);
    chk("rst_err", err);
    chk("rst_rep_idx", rep_idx);
    rst = 1'b0;
    @(negedge clk);

    sweep_case("t1", 0, 2, 5, 1);
    sweep_case("t2", 9, 3, 6, 2);

    // Inverted bounds: rejected with sticky error, counter never enabled.
    push(1); push(0); push(0); push(1);
    do_start(7, 4, 1);
    chk("inv_err", err);
    chk("inv_busy", busy);
    en_seen = 0;
    repeat (5) begin
      if (cnt_en !== 1'b0) en_seen++;
      @(negedge clk);
    end
    chk("inv_en_seen", en_seen);
    chk("inv_err_sticky", err);
    sweep_case("t3", 1, 2, 3, 1);

    sweep_case("t4", 5, 5, 5, 3);

    // Free-running full-range sweep, stopped mid-RISE.
    load(0);
    do_start(0, 15, 0);
    repeat (65) @(negedge clk);
    push(2); push(1); push(0);
    chk("free_rep_idx", rep_idx);
    chk("free_busy", busy);
    chk("free_count", cnt);
    repeat (3) @(negedge clk);
    push(1); push(1); push(3);
    chk("free_rise_en", cnt_en);
    chk("free_rise_dir", cnt_dir);
    chk("free_rise_count", cnt);
    stop = 1'b1;
    #1;
    push(0);
    chk("stop_en_comb", cnt_en);
    @(negedge clk);
    stop = 1'b0;
    push(0); push(0); push(2); push(3); push(0);
    chk("stop_busy", busy);
    chk("stop_done", done);
    chk("stop_rep_idx", rep_idx);
    chk("stop_count", cnt);
    chk("stop_err", err);

    // rep_idx wraps after 256 one-point triangles.
    load(5);
    do_start(5, 5, 0);
    repeat (513) @(negedge clk);
    push(0); push(1);
    chk("wrap_rep_idx", rep_idx);
    chk("wrap_busy", busy);
    repeat (2) @(negedge clk);
    push(1);
    chk("wrap_rep_idx_next", rep_idx);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    push(0);
    chk("wrap_stop_busy", busy);

    // Counter pushed above hi during RISE.
    load(2);
    do_start(2, 5, 1);
    @(negedge clk);
    ld = 1'b1; ld_val = 4'd6;
    @(negedge clk);
    ld = 1'b0;
    push(0); push(1); push(6);
    chk("dist_en", cnt_en);
    chk("dist_busy", busy);
    chk("dist_count", cnt);
    @(negedge clk);
    push(1); push(0); push(0);
    chk("dist_err", err);
    chk("dist_busy_next", busy);
    chk("dist_done", done);

    // Asynchronous reset in the middle of FALL.
    load(2);
    push(0);
    do_start(2, 5, 1);
    chk("rstf_err_clr", err);
    repeat (6) @(negedge clk);
    push(1); push(0); push(4); push(1);
    chk("rstf_en", cnt_en);
    chk("rstf_dir", cnt_dir);
    chk("rstf_count", cnt);
    chk("rstf_busy", busy);
    rst = 1'b1;
    #1;
    push(0); push(0); push(0); push(0); push(0); push(0);
    chk("rstf_async_en", cnt_en);
    chk("rstf_async_dir", cnt_dir);
    chk("rstf_async_busy", busy);
    chk("rstf_async_done", done);
    chk("rstf_async_err", err);
    chk("rstf_async_rep_idx", rep_idx);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
